// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the camera configuration sequencer: opcodes,
// FSM state encoding and command ROM entry field positions.
package cam_cfg_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_DELAY = 2'b01,
    OP_END   = 2'b10,
    OP_CHECK = 2'b11
  } opcode_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_REQ,
    S_WAIT_DONE,
    S_GAP,
    S_DELAY,
    S_DONE,
    S_ERR
  } state_e;

  // ROM entry layout: [31:30] opcode, [29:24] reserved, [23:16] reg H,
  // [15:8] reg L, [7:0] data; a DELAY entry reuses [15:0] as its tick count.
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 30;
  localparam int RSVD_HI = 29;
  localparam int RSVD_LO = 24;
  localparam int REGH_HI = 23;
  localparam int REGH_LO = 16;
  localparam int REGL_HI = 15;
  localparam int REGL_LO = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;
  localparam int TICK_HI = 15;
  localparam int TICK_LO = 0;
  localparam int TICK_W  = TICK_HI - TICK_LO + 1;

endpackage

// File: rtl/cfg_timer.sv
// Loadable down-counter shared by the delay, inter-request gap and
// completion-timeout functions of the configuration sequencer.
module cfg_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: state is only ever written with non-blocking assignments so every
  // flop samples its inputs as they were before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cam_i2c_cfg_seq.sv
// Camera sensor bring-up sequencer: walks a command ROM and issues single
// register I2C writes and read-checks with programmed delays and a timeout.
module cam_i2c_cfg_seq
  import cam_cfg_pkg::*;
#(
  parameter int         ROM_AW     = 8,
  parameter logic [6:0] DEV_ADDR   = 7'h10,
  parameter int         DELAY_UNIT = 100000,
  parameter int         TIMEOUT    = 1048576,
  parameter int         GAP        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_addr,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              i2c_rqt,
  output logic              cmd,
  output logic [6:0]        addr_dev,
  output logic [7:0]        addr_reg_H,
  output logic [7:0]        addr_reg_L,
  output logic [7:0]        data_wr_H,
  output logic [7:0]        data_wr_L,
  input  logic [7:0]        data_rd,
  input  logic              data_rdy,
  input  logic              i2c_done
);

  // Timer width covers both the longest delay and the completion timeout.
  localparam int DLY_W = TICK_W + $clog2(DELAY_UNIT + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int TW    = (DLY_W > TO_W) ? DLY_W : TO_W;

  state_e            state, next_state;
  opcode_e           op;
  logic [TICK_W-1:0] ticks;
  logic [TW-1:0]     dly_load;
  logic              done_q;
  logic              done_rise;
  logic              rd_seen;
  logic [7:0]        rd_q;
  logic              check_bad;
  logic              last_entry;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_en;
  logic              tmr_zero;
  logic              unused_rsvd;

  assign op          = opcode_e'(rom_data[OPC_HI:OPC_LO]);
  assign ticks       = rom_data[TICK_HI:TICK_LO];
  assign dly_load    = TW'(ticks) * TW'(DELAY_UNIT) - TW'(1);
  assign unused_rsvd = ^rom_data[RSVD_HI:RSVD_LO];

  // Only a fresh rising edge completes a request; a level left high by the
  // previous transaction is filtered out by the registered copy.
  assign done_rise  = i2c_done & ~done_q;
  // Read data arriving in the same cycle as completion still counts.
  assign check_bad  = !cmd && !((rd_seen || data_rdy) &&
                                ((data_rdy ? data_rd : rd_q) == data_wr_H));
  assign last_entry = &rom_addr;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign addr_dev  = DEV_ADDR;
  assign data_wr_L = 8'h00;

  cfg_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_en     = 1'b0;
    case (state)
      S_IDLE:   if (start) next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_WRITE, OP_CHECK: next_state = S_REQ;
          OP_DELAY: begin
            tmr_load = 1'b1;
            if (ticks == '0) begin
              next_state = S_GAP;
              tmr_val    = TW'(GAP - 1);
            end else begin
              next_state = S_DELAY;
              tmr_val    = dly_load;
            end
          end
          default: next_state = S_DONE;
        endcase
      end
      S_REQ: begin
        next_state = S_WAIT_DONE;
        tmr_load   = 1'b1;
        tmr_val    = TW'(TIMEOUT - 1);
      end
      S_WAIT_DONE: begin
        tmr_en = 1'b1;
        if (done_rise) begin
          if (check_bad) begin
            next_state = S_ERR;
          end else begin
            next_state = S_GAP;
            tmr_load   = 1'b1;
            tmr_val    = TW'(GAP - 1);
          end
        end else if (tmr_zero) begin
          next_state = S_ERR;
        end
      end
      S_DELAY: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          next_state = S_GAP;
          tmr_load   = 1'b1;
          tmr_val    = TW'(GAP - 1);
        end
      end
      S_GAP: begin
        tmr_en = 1'b1;
        if (tmr_zero) next_state = last_entry ? S_DONE : S_FETCH;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      done_q     <= 1'b0;
      rd_seen    <= 1'b0;
      rd_q       <= '0;
      rom_addr   <= '0;
      err_addr   <= '0;
      error      <= 1'b0;
      i2c_rqt    <= 1'b0;
      cmd        <= 1'b0;
      addr_reg_H <= '0;
      addr_reg_L <= '0;
      data_wr_H  <= '0;
    end else begin
      state   <= next_state;
      done_q  <= i2c_done;
      i2c_rqt <= (next_state == S_REQ) || (next_state == S_WAIT_DONE);
      case (state)
        S_IDLE: if (start) begin
          error    <= 1'b0;
          rom_addr <= '0;
        end
        S_DECODE: begin
          addr_reg_H <= rom_data[REGH_HI:REGH_LO];
          addr_reg_L <= rom_data[REGL_HI:REGL_LO];
          data_wr_H  <= rom_data[DATA_HI:DATA_LO];
          if (op == OP_WRITE || op == OP_CHECK) cmd <= (op == OP_WRITE);
        end
        S_REQ: rd_seen <= 1'b0;
        S_WAIT_DONE: if (data_rdy) begin
          rd_seen <= 1'b1;
          rd_q    <= data_rd;
        end
        S_GAP: if (tmr_zero && !last_entry) rom_addr <= rom_addr + 1'b1;
        default: ;
      endcase
      if (next_state == S_ERR && state != S_ERR) begin
        error    <= 1'b1;
        err_addr <= rom_addr;
      end
    end
  end

endmodule

// File: tb/tb_cam_i2c_cfg_seq.sv
// Self-checking bench for cam_i2c_cfg_seq: ROM and I2C core models plus a
// request scoreboard; each scenario task checks its own timing and flags.
module tb_cam_i2c_cfg_seq;
  import cam_cfg_pkg::*;

  localparam int ROM_AW     = 2;
  localparam int DELAY_UNIT = 10;
  localparam int TIMEOUT    = 1000;
  localparam int GAP_CYC    = 4;
  localparam int CORE_LAT   = 500;  // i2c_done rises this many cycles after i2c_rqt rises

  typedef struct packed {
    logic       cmd;
    logic [7:0] reg_h;
    logic [7:0] reg_l;
    logic [7:0] data;
  } req_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, error;
  logic [ROM_AW-1:0] err_addr, rom_addr;
  logic [31:0]       rom_data = '0;
  logic              i2c_rqt, cmd;
  logic [6:0]        addr_dev;
  logic [7:0]        addr_reg_H, addr_reg_L, data_wr_H, data_wr_L;
  logic [7:0]        data_rd = '0;
  logic              data_rdy = 1'b0;
  logic              i2c_done = 1'b0;

  logic [31:0] rom [4];
  req_t        exp_q[$];
  req_t        sb_exp, sb_got, snap;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          req_cnt = 0;
  int          stab_err = 0;
  int          wrap_err = 0;
  bit          saw_last = 1'b0;
  bit          rqt_mon = 1'b0;
  bit          core_on = 1'b1;
  bit          rdy_on = 1'b1;
  logic [7:0]  rd_val = '0;
  logic        rqt_q;
  bit          active;
  int          lat;

  cam_i2c_cfg_seq #(
    .ROM_AW     (ROM_AW),
    .DEV_ADDR   (7'h10),
    .DELAY_UNIT (DELAY_UNIT),
    .TIMEOUT    (TIMEOUT),
    .GAP        (GAP_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_addr   (err_addr),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .i2c_rqt    (i2c_rqt),
    .cmd        (cmd),
    .addr_dev   (addr_dev),
    .addr_reg_H (addr_reg_H),
    .addr_reg_L (addr_reg_L),
    .data_wr_H  (data_wr_H),
    .data_wr_L  (data_wr_L),
    .data_rd    (data_rd),
    .data_rdy   (data_rdy),
    .i2c_done   (i2c_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous command ROM: data follows the address by one cycle.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // I2C core model and request scoreboard. i2c_done is held high until the
  // next request, so a stale level is present whenever a new request starts.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rqt_q    <= 1'b0;
      i2c_done <= 1'b0;
      data_rdy <= 1'b0;
      active   <= 1'b0;
      lat      <= 0;
    end else begin
      rqt_q    <= i2c_rqt;
      data_rdy <= 1'b0;
      if (i2c_rqt && !rqt_q) begin
        req_cnt  <= req_cnt + 1;
        sb_got   = '{cmd: cmd, reg_h: addr_reg_H, reg_l: addr_reg_L, data: data_wr_H};
        n_checks = n_checks + 1;
        if (exp_q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL req_unexpected: got %h, want no request", sb_got);
        end else begin
          sb_exp = exp_q.pop_front();
          if (sb_got !== sb_exp) begin
            n_fail = n_fail + 1;
            $display("FAIL req_fields: got %h, want %h", sb_got, sb_exp);
          end
        end
        i2c_done <= 1'b0;
        active   <= core_on;
        lat      <= CORE_LAT - 2;
      end else if (active) begin
        if (lat == 1 && rdy_on) begin
          data_rdy <= 1'b1;
          data_rd  <= rd_val;
        end
        if (lat == 0) begin
          i2c_done <= 1'b1;
          active   <= 1'b0;
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  // Request fields must hold while i2c_rqt is high; rom_addr must not wrap.
  always @(negedge clk) begin
    if (i2c_rqt && rqt_mon &&
        (snap !== {cmd, addr_reg_H, addr_reg_L, data_wr_H})) stab_err++;
    snap    = {cmd, addr_reg_H, addr_reg_L, data_wr_H};
    rqt_mon = i2c_rqt;
    if (!busy) saw_last = 1'b0;
    else if (rom_addr == 2'd3) saw_last = 1'b1;
    else if (saw_last) wrap_err++;
  end

  function automatic logic [31:0] mk(opcode_e op, logic [7:0] h, logic [7:0] l, logic [7:0] d);
    return {op, 6'b0, h, l, d};
  endfunction

  function automatic req_t rq(logic c, logic [7:0] h, logic [7:0] l, logic [7:0] d);
    return '{cmd: c, reg_h: h, reg_l: l, data: d};
  endfunction

  // Pulses start for one cycle; s is the cycle start is sampled in.
  task automatic run_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int limit, output int t, output bit expired);
    expired = 1'b1;
    t = -1;
    for (int i = 0; i < limit; i++) begin
      if (done || error) begin
        t = cyc;
        expired = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, error, i2c_rqt, cmd} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, want 00000", {busy, done, error, i2c_rqt, cmd});
    end
    n_checks++;
    if ({rom_addr, err_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: got rom=%0d err=%0d, want 0 0", rom_addr, err_addr);
    end
    n_checks++;
    if ({addr_reg_H, addr_reg_L, data_wr_H, data_wr_L} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h, want 0", {addr_reg_H, addr_reg_L, data_wr_H, data_wr_L});
    end
    n_checks++;
    if (addr_dev !== 7'h10) begin
      n_fail++;
      $display("FAIL addr_dev: got %h, want 10", addr_dev);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write;
    int s, t;
    bit exp;
    rom[0] = mk(OP_WRITE, 8'h01, 8'h00, 8'h01);
    rom[1] = mk(OP_END, 8'h00, 8'h00, 8'h00);
    exp_q.push_back(rq(1'b1, 8'h01, 8'h00, 8'h01));
    run_start(s);
    n_checks++;
    if (busy !== 1'b1 || rom_addr !== 2'd0) begin
      n_fail++;
      $display("FAIL write_busy: got busy=%b rom_addr=%0d, want 1 0", busy, rom_addr);
    end
    wait_end(2000, t, exp);
    n_checks++;
    if (exp || {done, error} !== 2'b10) begin
      n_fail++;
      $display("FAIL write_end: got expired=%0b done=%b error=%b, want 0 1 0", exp, done, error);
    end
    // FETCH, DECODE, REQ; 500-cycle core; GAP 4; FETCH, DECODE of END; DONE.
    n_checks++;
    if (t != s + 3 + CORE_LAT + 3 + GAP_CYC) begin
      n_fail++;
      $display("FAIL write_latency: got %0d, want %0d", t - s, 3 + CORE_LAT + 3 + GAP_CYC);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || exp_q.size() != 0 || stab_err != 0) begin
      n_fail++;
      $display("FAIL write_after: got busy=%b done=%b pending=%0d unstable=%0d, want 0 0 0 0",
               busy, done, exp_q.size(), stab_err);
    end
  endtask

  task automatic test_delay;
    int s, t;
    bit exp;
    rom[0] = mk(OP_DELAY, 8'h00, 8'h00, 8'h03);
    rom[1] = mk(OP_END, 8'h00, 8'h00, 8'h00);
    run_start(s);
    wait_end(500, t, exp);
    // DECODE at s+2, then 30 delay cycles, GAP and the END entry.
    n_checks++;
    if (exp || error !== 1'b0 || t < s + 2 + 30 + GAP_CYC + 3 || t > s + 2 + 30 + GAP_CYC + 4) begin
      n_fail++;
      $display("FAIL delay3_end: got expired=%0b error=%b after_decode=%0d, want 0 0 %0d..%0d",
               exp, error, t - s - 2, 30 + GAP_CYC + 3, 30 + GAP_CYC + 4);
    end
    rom[0] = mk(OP_DELAY, 8'h00, 8'h00, 8'h00);
    run_start(s);
    wait_end(500, t, exp);
    n_checks++;
    if (exp || error !== 1'b0 || t != s + 2 + GAP_CYC + 3) begin
      n_fail++;
      $display("FAIL delay0_end: got expired=%0b error=%b after_decode=%0d, want 0 0 %0d",
               exp, error, t - s - 2, GAP_CYC + 3);
    end
  endtask

  task automatic test_check;
    int s, t;
    bit exp;
    rom[0] = mk(OP_CHECK, 8'h30, 8'h0A, 8'h56);
    rom[1] = mk(OP_END, 8'h00, 8'h00, 8'h00);
    rd_val = 8'h56;
    exp_q.push_back(rq(1'b0, 8'h30, 8'h0A, 8'h56));
    run_start(s);
    wait_end(2000, t, exp);
    n_checks++;
    if (exp || {done, error} !== 2'b10) begin
      n_fail++;
      $display("FAIL check_match: got expired=%0b done=%b error=%b, want 0 1 0", exp, done, error);
    end
    rd_val = 8'h57;
    exp_q.push_back(rq(1'b0, 8'h30, 8'h0A, 8'h56));
    run_start(s);
    wait_end(2000, t, exp);
    n_checks++;
    if (exp || {done, error} !== 2'b01 || err_addr !== 2'd0 || t != s + 3 + CORE_LAT + 1) begin
      n_fail++;
      $display("FAIL check_mismatch: got expired=%0b done=%b error=%b err_addr=%0d cyc=%0d, want 0 0 1 0 %0d",
               exp, done, error, err_addr, t - s, 3 + CORE_LAT + 1);
    end
    rd_val = 8'h56;
    rdy_on = 1'b0;
    exp_q.push_back(rq(1'b0, 8'h30, 8'h0A, 8'h56));
    run_start(s);
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_clear: got %b, want 0", error);
    end
    wait_end(2000, t, exp);
    n_checks++;
    if (exp || {done, error} !== 2'b01) begin
      n_fail++;
      $display("FAIL check_no_rdy: got expired=%0b done=%b error=%b, want 0 0 1", exp, done, error);
    end
    rdy_on = 1'b1;
  endtask

  task automatic test_timeout;
    int s, t, r;
    bit exp;
    rom[0] = mk(OP_DELAY, 8'h00, 8'h00, 8'h00);
    rom[1] = mk(OP_WRITE, 8'h12, 8'h34, 8'h77);
    exp_q.push_back(rq(1'b1, 8'h12, 8'h34, 8'h77));
    core_on = 1'b0;
    run_start(s);
    r = -1;
    for (int i = 0; i < 100; i++) begin
      if (i2c_rqt) begin
        r = cyc;
        break;
      end
      @(negedge clk);
    end
    wait_end(1200, t, exp);
    n_checks++;
    if (r < 0 || exp || t != r + TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL timeout_cycle: got req_seen=%0b expired=%0b error_after_req=%0d, want 1 0 %0d",
               r >= 0, exp, t - r, TIMEOUT + 1);
    end
    n_checks++;
    if (error !== 1'b1 || i2c_rqt !== 1'b0 || err_addr !== 2'd1) begin
      n_fail++;
      $display("FAIL timeout_state: got error=%b rqt=%b err_addr=%0d, want 1 0 1", error, i2c_rqt, err_addr);
    end
    core_on = 1'b1;
  endtask

  task automatic test_no_wrap;
    int s, t;
    bit exp;
    for (int i = 0; i < 4; i++) begin
      rom[i] = mk(OP_WRITE, 8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h60 + i));
      exp_q.push_back(rq(1'b1, 8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h60 + i)));
    end
    run_start(s);
    wait_end(4000, t, exp);
    // Four entries of FETCH, DECODE, REQ, core wait and GAP; the last GAP ends the run.
    n_checks++;
    if (exp || {done, error} !== 2'b10 || t != s + 1 + 4 * (3 + CORE_LAT + GAP_CYC)) begin
      n_fail++;
      $display("FAIL nowrap_end: got expired=%0b done=%b error=%b cyc=%0d, want 0 1 0 %0d",
               exp, done, error, t - s, 1 + 4 * (3 + CORE_LAT + GAP_CYC));
    end
    n_checks++;
    if (rom_addr !== 2'd3 || wrap_err != 0 || exp_q.size() != 0 || stab_err != 0) begin
      n_fail++;
      $display("FAIL nowrap_addr: got rom_addr=%0d wraps=%0d pending=%0d unstable=%0d, want 3 0 0 0",
               rom_addr, wrap_err, exp_q.size(), stab_err);
    end
  endtask

  task automatic test_reset_mid_run;
    int s, t, base;
    bit exp;
    for (int i = 0; i < 4; i++) begin
      rom[i] = mk(OP_WRITE, 8'(8'h70 + i), 8'(8'h80 + i), 8'(8'h90 + i));
      exp_q.push_back(rq(1'b1, 8'(8'h70 + i), 8'(8'h80 + i), 8'(8'h90 + i)));
    end
    base = req_cnt;
    run_start(s);
    for (int i = 0; i < 3000 && req_cnt < base + 3; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    n_checks++;
    if (req_cnt != base + 3 || i2c_rqt !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reach: got requests=%0d rqt=%b, want 3 1", req_cnt - base, i2c_rqt);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, error, i2c_rqt, cmd, rom_addr, addr_reg_H, addr_reg_L, data_wr_H} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%b rqt=%b cmd=%b rom_addr=%0d regs=%h, want all 0",
               busy, i2c_rqt, cmd, rom_addr, {addr_reg_H, addr_reg_L, data_wr_H});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(rq(1'b1, 8'(8'h70 + i), 8'(8'h80 + i), 8'(8'h90 + i)));
    base = req_cnt;
    run_start(s);
    for (int i = 0; i < 3000 && req_cnt < base + 2; i++) @(negedge clk);
    start = 1'b1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_busy: got %b, want 1", busy);
    end
    @(negedge clk);
    start = 1'b0;
    wait_end(4000, t, exp);
    n_checks++;
    if (exp || {done, error} !== 2'b10 || t != s + 1 + 4 * (3 + CORE_LAT + GAP_CYC) || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midrun_rerun: got expired=%0b done=%b error=%b cyc=%0d pending=%0d, want 0 1 0 %0d 0",
               exp, done, error, t - s, exp_q.size(), 1 + 4 * (3 + CORE_LAT + GAP_CYC));
    end
  endtask

  task automatic test_back_to_back;
    int s;
    rom[0] = mk(OP_END, 8'h00, 8'h00, 8'h00);
    run_start(s);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: got %b, want 1", done);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_start_ignored: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rom[i] = '0;
    test_reset();
    test_write();
    test_delay();
    test_check();
    test_timeout();
    test_no_wrap();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want completion within 200000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cam_i2c_cfg_seq.md
# cam_i2c_cfg_seq

Table-driven configuration sequencer that brings up one CSI-2 camera sensor by walking a synchronous command ROM and issuing single-register writes and reads to the I2C byte engine. It sits between the system reset/power-up logic and the I2C core: it pulses the core's request input, waits for completion, and inserts programmed delays. It can verify read-back values and reports completion or error to the bridge top level.

## Interface
- `ROM_AW`, 8: command ROM address width; the table holds at most 2^ROM_AW entries.
- `DEV_ADDR`, 7'h10: 7-bit sensor slave address, driven unchanged on `addr_dev`.
- `DELAY_UNIT`, 100000: clk cycles per delay tick (1 ms at 100 MHz).
- `TIMEOUT`, 1048576: maximum clk cycles to wait for `i2c_done` after a request.
- `GAP`, 4: minimum clk cycles `i2c_rqt` stays low between requests (≥3).

Ports:
- `clk`  in  1  system clock; one clock; all logic is on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  single-cycle pulse that begins a table run; ignored while `busy`=1.
- `busy`  out  1  high from the cycle after an accepted `start` until `done` or `error`.
- `done`  out  1  one-cycle pulse at successful end of table.
- `error`  out  1  sticky; set on timeout or read mismatch; cleared by the next accepted `start`.
- `err_addr`  out  ROM_AW  ROM index of the failing entry; valid while `error`=1.
- `rom_addr`  out  ROM_AW  command ROM address.
- `rom_data`  in  32  ROM word, valid one cycle after `rom_addr` changes.
- `i2c_rqt`  out  1  request to the I2C core; the core acts on its rising edge.
- `cmd`  out  1  1 = write, 0 = read.
- `addr_dev`  out  7  equals `DEV_ADDR`.
- `addr_reg_H`, `addr_reg_L`  out  8 each  register address.
- `data_wr_H`  out  8  write data. `data_wr_L` is tied to 8'h00.
- `data_rd`  in  8  read data from the core.
- `data_rdy`  in  1  pulse when `data_rd` is valid.
- `i2c_done`  in  1  completion from the core; may stay high for many cycles.

## Operation
- Entry format: [31:30] opcode, [23:16] reg addr H, [15:8] reg addr L, [7:0] data. For DELAY, [15:0] is the tick count.
- Opcodes:
  - 00 WRITE: write data to the register.
  - 01 DELAY: wait for the programmed tick count.
  - 10 END: finish the run.
  - 11 CHECK: read the register and compare with data.
- FSM states: IDLE, FETCH, DECODE, REQ, WAIT_DONE, GAP, DELAY, DONE, ERR.
- IDLE: on `start`, clear `error`, set `rom_addr`=0, go to FETCH.
- FETCH (1 cycle): go to DECODE.
- DECODE:
  - Latch the address/data fields into the output registers.
  - WRITE or CHECK: go to REQ, with `cmd`=1 for WRITE and `cmd`=0 for CHECK.
  - DELAY: go to DELAY, or straight to GAP if the count is 0.
  - END: go to DONE.
- REQ: assert `i2c_rqt`, clear the timeout counter, go to WAIT_DONE.
- WAIT_DONE:
  - Hold `i2c_rqt`=1.
  - Advance on a rising edge of `i2c_done`, detected with a registered copy of `i2c_done`; a level already high on entry does not count.
  - CHECK: capture `data_rd` on `data_rdy`. At done, if the captured value ≠ expected data, or no `data_rdy` was seen, go to ERR.
  - Timeout counter reaching `TIMEOUT` → ERR.
  - Otherwise → GAP.
- GAP:
  - Hold `i2c_rqt`=0 for `GAP` cycles, then advance.
  - If `rom_addr` = 2^ROM_AW−1, go to DONE; this is an implicit END and the address must not wrap.
  - Otherwise increment `rom_addr` and go to FETCH.
- DELAY: count `ticks × DELAY_UNIT` cycles, then go to GAP.
- DONE: pulse `done`, go to IDLE.
- ERR: set `error`, latch `err_addr` = `rom_addr`, drop `i2c_rqt`, go to IDLE.

## Timing
- Reset values:
  - `busy`, `done`, `error`, `i2c_rqt`, `cmd`: 0.
  - `rom_addr`, `err_addr`, `addr_reg_*`, `data_wr_H`: 0.
- `start` → `busy`=1 on the next cycle; `rom_addr`=0 is presented in the same cycle.
- Per WRITE entry, the sequencer overhead outside the I2C transaction is 3 + `GAP` cycles.
- `i2c_rqt` rises exactly once per WRITE or CHECK entry. It is never high in DELAY, GAP or IDLE.
- Address, data and `cmd` outputs are stable from the REQ cycle until GAP ends.
- If `start` and a terminal event (DONE or ERR) fall in the same cycle, `start` is ignored.
- If `rst_n` is asserted mid-run, the block returns to IDLE immediately with all outputs at reset values. The next `start` restarts from entry 0.

## Structure
- Shared package `cam_cfg_pkg`:
  - opcode constants OP_WRITE, OP_DELAY, OP_END, OP_CHECK.
  - FSM state encoding.
  - entry field bit positions.
- One sub-module, `cfg_timer`: a loadable down-counter shared by the DELAY, GAP and WAIT_DONE timeout functions. It has a load value input, an enable input and a `zero` flag output.

## Test plan
- Table {WRITE 0x0100←0x01, END}, with a core model that gives done after 500 cycles:
  - exactly one `i2c_rqt` rise, with addr_H=0x01, addr_L=0x00, data=0x01, `cmd`=1;
  - `done` pulses about 500 + 7 cycles after `start`.
- Table {DELAY 3, END} with DELAY_UNIT=10:
  - no `i2c_rqt`;
  - `done` pulses 30 + GAP + 4 cycles after DECODE.
- CHECK 0x300A expecting 0x56, with the model returning 0x56 and then 0x57 on a second run:
  - first run gives `done` with `error`=0;
  - second run gives `error`=1 with `err_addr`=0.
- Model never asserts `i2c_done`, TIMEOUT=1000:
  - `error` sets 1001 cycles after REQ;
  - `i2c_rqt` returns to 0.
- ROM_AW=2 with four WRITE entries and no END:
  - four requests are issued, then `done`;
  - `rom_addr` never wraps to 0.
- `rst_n` pulsed low during WAIT_DONE of entry 2, then `start` again:
  - outputs take reset values immediately;
  - the second run begins at entry 0;
  - a `start` pulsed while `busy` is ignored.
